// File: rtl/if_id_queue_pkg.sv
// Shared defines for the fetch/decode instruction queue.
// Bus widths, zero/NOP words and the width helpers live here.
package if_id_queue_pkg;

   localparam int XLEN       = 32;
   localparam int INST_W_DEF = XLEN;
   localparam int ADDR_W_DEF = XLEN;
   localparam int DEPTH_DEF  = 4;

   localparam logic [XLEN-1:0] ZERO_WORD = '0;
   // Decode sees an all-zero word whenever the queue is empty.
   localparam logic [XLEN-1:0] NOP_INST  = ZERO_WORD;

   function automatic int clog2(input int n);
      return $clog2(n);
   endfunction

   function automatic int cnt_w(input int depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The queue takes the slave side; the surrounding pipeline the master.
interface if_id_queue_if
   import if_id_queue_pkg::*;
#(
   parameter int INST_W = INST_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
);

   logic                      if_valid;
   logic                      if_ready;
   logic [INST_W-1:0]         if_inst;
   logic [ADDR_W-1:0]         if_pc;
   logic                      id_valid;
   logic                      id_ready;
   logic [INST_W-1:0]         id_inst;
   logic [ADDR_W-1:0]         id_pc;
   logic                      flush;
   logic [cnt_w(DEPTH)-1:0]   count;
   logic                      full;
   logic                      empty;

   modport master (
      output if_valid, if_inst, if_pc,
      output id_ready, flush,
      input  if_ready, id_valid, id_inst, id_pc,
      input  count, full, empty
   );

   modport slave (
      input  if_valid, if_inst, if_pc,
      input  id_ready, flush,
      output if_ready, id_valid, id_inst, id_pc,
      output count, full, empty
   );

endinterface

// File: rtl/if_id_queue.sv
// Fall-through FIFO between fetch and decode.
// Flush wins over push/pop; storage is never cleared, only pointers.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int INST_W = INST_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input logic            clk,
   input logic            rst,
   if_id_queue_if.slave   q
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   cnt;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   assign push  = q.if_valid && !full && !q.flush;
   assign pop   = !empty && q.id_ready && !q.flush;

   assign q.if_ready = !full;
   assign q.id_valid = !empty;
   assign q.full     = full;
   assign q.empty    = empty;
   assign q.count    = cnt;

   // Stale storage must not leak out when empty.
   assign q.id_inst = empty ? INST_W'(NOP_INST)  : mem[head].inst;
   assign q.id_pc   = empty ? ADDR_W'(ZERO_WORD) : mem[head].pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (q.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push)
            tail <= tail + PTR_W'(1);
         if (pop)
            head <= head + PTR_W'(1);
         unique case (1'b1)
            push && !pop: cnt <= cnt + CNT_W'(1);
            pop && !push: cnt <= cnt - CNT_W'(1);
            default:      cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[tail] <= '{pc: q.if_pc, inst: q.if_inst};
   end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter INST_W, default 32, instruction word width.
REQ-002 Parameter ADDR_W, default 32, program-counter width.
REQ-003 Parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low: 0 = reset asserted.
REQ-006 if_valid  input  1  fetch stage presents an instruction.
REQ-007 if_ready  output  1  queue accepts an instruction this cycle.
REQ-008 if_inst  input  INST_W  fetched instruction.
REQ-009 if_pc  input  ADDR_W  address of the fetched instruction.
REQ-010 id_valid  output  1  head entry is valid for decode.
REQ-011 id_ready  input  1  decode consumes the head entry this cycle.
REQ-012 id_inst  output  INST_W  head instruction, or all-zero (NOP) when empty.
REQ-013 id_pc  output  ADDR_W  head address, or all-zero when empty.
REQ-014 flush  input  1  discard all queued and incoming instructions.
REQ-015 count  output  clog2(DEPTH+1)  number of occupied entries.
REQ-016 full / empty  output  1 each  count==DEPTH / count==0.

Function
REQ-017 Push occurs when if_valid && if_ready && !flush; entry written at tail, tail advances modulo DEPTH.
REQ-018 Pop occurs when id_valid && id_ready && !flush; head advances modulo DEPTH.
REQ-019 if_ready = !full; it does not depend on id_ready.
REQ-020 id_valid = !empty; id_inst/id_pc are driven combinationally from the head entry (first-word fall-through).
REQ-021 When empty, id_inst and id_pc are zero regardless of stale storage.
REQ-022 Latency: an instruction pushed in cycle N is visible on id_* in cycle N+1 if the queue was empty.
REQ-023 Simultaneous push and pop when neither full nor empty: both take effect and count is unchanged.
REQ-024 Simultaneous push and pop when empty: push only; the pop is ignored because id_valid is 0.
REQ-025 Push attempt when full: ignored; the stored data and count are unchanged.
REQ-026 Pop attempt when empty: ignored; no pointer movement.
REQ-027 Pointer wrap: head and tail wrap from DEPTH-1 to 0 with no bubble and no loss.
REQ-028 Flush has priority over push and pop: next cycle count=0, empty=1, head=tail; a concurrent push is dropped.
REQ-029 Flush and reset do not need to clear storage contents, only pointers and count.
REQ-030 count is updated in the same edge as the pointers: +1 for push only, -1 for pop only, 0 for both or neither.
REQ-031 Handshake signals are never X after reset; the queue neither duplicates nor reorders entries (strict FIFO).

Reset
REQ-032 On rst=0, immediately (asynchronously): head=0, tail=0, count=0, empty=1, full=0, if_ready=1, id_valid=0, id_inst=0, id_pc=0.
REQ-033 Reset asserted mid-operation discards all entries; on the first edge after rst returns to 1, normal pushes are accepted.

Structure
REQ-034 ZeroWord, instruction/address bus widths and the NOP encoding come from the shared defines package; no local redefinition.
REQ-035 clog2 helper and the count width are computed from parameters in the shared package, not hard-coded.
REQ-036 A single flat module is used; no sub-module is required. Storage is a register array of DEPTH entries, each {pc, inst}.

Verification
REQ-037 Fill/drain: push 0x11111111..0x44444444 (pc 0x0,0x4,0x8,0xC) with id_ready=0 -> full=1, count=4, if_ready=0; then id_ready=1 -> pops in the same order over 4 cycles, then empty=1, id_inst=0.
REQ-038 Overflow: when full, push 0xDEADBEEF -> ignored; the drained sequence contains no 0xDEADBEEF; count stays 4.
REQ-039 Streaming wrap: continuous push and pop of 12 sequential instructions with DEPTH=4 -> all 12 are output in order with pc incrementing by 4; pointers wrap 3 times.
REQ-040 Flush: with count=3 and a simultaneous push of 0xAAAA0000 plus flush=1 -> next cycle count=0, id_valid=0, id_inst=0; 0xAAAA0000 never appears.
REQ-041 Async reset: rst=0 between clock edges with count=2 -> outputs go to their reset values before the next edge; after release, a push of 0x12345678 appears one cycle later.
REQ-042 Parameter sweep: DEPTH=2 and DEPTH=8, INST_W=16 -> REQ-037 to REQ-040 pass with scaled counts.
